// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared types and constants for the ADC SPI master.
//   state_e     - frame sequencer states
//   FRAME_BITS  - bits clocked in per conversion
//   DATA_BITS   - conversion result width
//   LEAD_BITS   - leading bits that must read back as zero
//   lead_err()  - flags a frame whose leading bits are not all zero
//   shift_in()  - MSB-first shift of one received bit into a frame
package adc_spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    QUIET = 3'd4
  } state_e;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 12;
  localparam int LEAD_BITS  = 4;

  function automatic logic lead_err(input logic [FRAME_BITS-1:0] frame);
    return |frame[FRAME_BITS-1 -: LEAD_BITS];
  endfunction

  function automatic logic [FRAME_BITS-1:0] shift_in(input logic [FRAME_BITS-1:0] frame,
                                                     input logic                  bit_in);
    return {frame[FRAME_BITS-2:0], bit_in};
  endfunction

endpackage

// File: rtl/adc_spi_master_if.sv
// adc_spi_master_if: signal bundle between the ADC SPI master and its
// surroundings (ADC pins plus the result stream to consumers).
//   enable    - consumer allows conversions to start
//   miso      - ADC serial data
//   cs_n/sclk - ADC chip select and SPI clock
//   data, new_data, frame_err - result, strobe, leading-bit flag
//   busy      - a frame (including its quiet gap) is in progress
// Modports: master = the SPI master, slave = ADC/consumer side.
interface adc_spi_master_if;
  import adc_spi_pkg::*;

  logic                 enable;
  logic                 miso;
  logic                 cs_n;
  logic                 sclk;
  logic [DATA_BITS-1:0] data;
  logic                 new_data;
  logic                 frame_err;
  logic                 busy;

  modport master (
    input  enable, miso,
    output cs_n, sclk, data, new_data, frame_err, busy
  );

  modport slave (
    output enable, miso,
    input  cs_n, sclk, data, new_data, frame_err, busy
  );
endinterface

// File: rtl/adc_spi_master_sclk_gen.sv
// spi_sclk_gen: SPI clock generator with a CLK_DIV half-period counter.
//   i_clk, i_rst_n - system clock, async active-low reset
//   i_run          - high while the frame sequencer will be in SHIFT next cycle
//   o_sclk         - registered SPI clock, idles high
//   o_rise/o_fall  - high in the cycle whose closing clk edge raises/drops o_sclk
// The first cycle of a run drops sclk straight away so the low phase of
// bit 0 starts exactly when SHIFT is entered.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);
  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_sclk;
  logic          r_active;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);
  // Edge pulses are looked-ahead so the owner can act on the same edge sclk moves.
  assign o_rise = i_run & r_active & w_wrap & ~r_sclk;
  assign o_fall = i_run & (~r_active | (w_wrap & r_sclk));
  assign o_sclk = r_sclk;

  // Half-period counter and sclk toggle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_sclk   <= 1'b1;
      r_active <= 1'b0;
    end else if (!i_run) begin
      r_cnt    <= '0;
      r_sclk   <= 1'b1;
      r_active <= 1'b0;
    end else if (!r_active) begin
      r_cnt    <= '0;
      r_sclk   <= 1'b0;
      r_active <= 1'b1;
    end else if (w_wrap) begin
      r_cnt    <= '0;
      r_sclk   <= ~r_sclk;
      r_active <= 1'b1;
    end else begin
      r_cnt    <= r_cnt + CW'(1);
      r_sclk   <= r_sclk;
      r_active <= 1'b1;
    end
  end
endmodule

// File: rtl/adc_spi_master.sv
// adc_spi_master: paces 12-bit ADC conversions with a free-running sample
// timer and reads one 16-bit frame (4 zero bits + 12 data bits, MSB first)
// per conversion over SPI mode 3.
//   clk, rst_n - system clock, async active-low reset
//   io_bus     - adc_spi_master_if.master: enable/miso in; cs_n, sclk,
//                data, new_data, frame_err, busy out
//   CLK_DIV       - sclk half-period in clk cycles (>=1)
//   SAMPLE_PERIOD - clk cycles between conversion starts (>=34*CLK_DIV+2)
module adc_spi_master
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000
) (
  input logic              clk,
  input logic              rst_n,
  adc_spi_master_if.master io_bus
);
  localparam int            TW         = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int            PW         = $clog2(2 * CLK_DIV);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [PW-1:0] SETUP_LAST = PW'(CLK_DIV - 1);
  // DONE already holds cs_n high, so it is the first of the 2*CLK_DIV quiet cycles.
  localparam logic [PW-1:0] QUIET_LAST = PW'(2 * CLK_DIV - 2);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("adc_spi_master: CLK_DIV must be at least 1");
  end
  if (SAMPLE_PERIOD < 34 * CLK_DIV + 2) begin : g_bad_period
    $error("adc_spi_master: SAMPLE_PERIOD must be at least 34*CLK_DIV+2");
  end

  state_e                r_state;
  state_e                w_next;
  logic [TW-1:0]         r_timer;
  logic [PW-1:0]         r_phase_cnt;
  logic [4:0]            r_bit_cnt;
  logic [FRAME_BITS-1:0] r_shift;
  logic                  r_cs_n;
  logic [DATA_BITS-1:0]  r_data;
  logic                  r_new_data;
  logic                  r_frame_err;
  logic                  r_busy;
  logic                  w_tick;
  logic                  w_sclk;
  logic                  w_rise;
  logic                  w_fall;

  assign w_tick = (r_timer == '0);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_run   (w_next == SHIFT),
    .o_sclk  (w_sclk),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // Free-running sample timer, independent of enable and FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (r_timer == TIMER_LAST) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        // A tick that finds the FSM elsewhere is simply lost, never queued.
        if (w_tick && io_bus.enable) begin
          w_next = SETUP;
        end else begin
          w_next = IDLE;
        end
      end
      SETUP: begin
        if (r_phase_cnt == SETUP_LAST) begin
          w_next = SHIFT;
        end else begin
          w_next = SETUP;
        end
      end
      SHIFT: begin
        // Bit 15 with sclk back high means the 16th sample has just been taken.
        if ((r_bit_cnt == 5'd15) && w_sclk) begin
          w_next = DONE;
        end else begin
          w_next = SHIFT;
        end
      end
      DONE: begin
        w_next = QUIET;
      end
      QUIET: begin
        if (r_phase_cnt == QUIET_LAST) begin
          w_next = IDLE;
        end else begin
          w_next = QUIET;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Cycles spent in the current state (times SETUP and QUIET).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase_cnt <= '0;
    end else if (w_next != r_state) begin
      r_phase_cnt <= '0;
    end else begin
      r_phase_cnt <= r_phase_cnt + PW'(1);
    end
  end

  // Current bit index: bumps on every sclk fall after the one that opens bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= 5'd0;
    end else if (r_state != SHIFT) begin
      r_bit_cnt <= 5'd0;
    end else if (w_fall) begin
      r_bit_cnt <= r_bit_cnt + 5'd1;
    end else begin
      r_bit_cnt <= r_bit_cnt;
    end
  end

  // Receive shift register, sampled on the edge that raises sclk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
    end else if (w_rise) begin
      r_shift <= shift_in(r_shift, io_bus.miso);
    end else begin
      r_shift <= r_shift;
    end
  end

  // Registered outputs, derived from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_n      <= 1'b1;
      r_busy      <= 1'b0;
      r_new_data  <= 1'b0;
      r_frame_err <= 1'b0;
      r_data      <= '0;
    end else begin
      r_cs_n      <= ~((w_next == SETUP) || (w_next == SHIFT));
      r_busy      <= (w_next != IDLE);
      r_new_data  <= (w_next == DONE);
      r_frame_err <= (w_next == DONE) ? lead_err(r_shift) : 1'b0;
      // A flagged frame still updates data; consumers decide what to do with it.
      r_data      <= (w_next == DONE) ? r_shift[DATA_BITS-1:0] : r_data;
    end
  end

  assign io_bus.cs_n      = r_cs_n;
  assign io_bus.sclk      = w_sclk;
  assign io_bus.data      = r_data;
  assign io_bus.new_data  = r_new_data;
  assign io_bus.frame_err = r_frame_err;
  assign io_bus.busy      = r_busy;
endmodule
